// File: rtl/ex_branch_if.sv
// Handshake bundle for the EX->MEM branch stage.
// Covers the upstream ALU side, the MEM side, the fetch redirect and the statistics.
interface ex_branch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_bgt;
    logic              in_beq;
    logic              in_bne;
    logic [1:0]        in_br_type;
    logic [ADDR_W-1:0] in_pc;
    logic [ADDR_W-1:0] in_imm;
    logic [4:0]        in_rd;
    logic              in_wb_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [4:0]        out_rd;
    logic              out_wb_en;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  taken_count;

    modport slave (
        input  in_valid, in_result, in_bgt, in_beq, in_bne,
        input  in_br_type, in_pc, in_imm, in_rd, in_wb_en,
        input  out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wb_en,
        output redirect_valid, redirect_pc, br_count, taken_count
    );

    modport master (
        output in_valid, in_result, in_bgt, in_beq, in_bne,
        output in_br_type, in_pc, in_imm, in_rd, in_wb_en,
        output out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wb_en,
        input  redirect_valid, redirect_pc, br_count, taken_count
    );
endinterface

// File: rtl/ex_branch_stage.sv
// EX->MEM stage: registers ALU results, resolves branches, squashes wrong path.
// A main register plus one skid entry keep the handshake fully registered.
module ex_branch_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int KILL_SLOTS = 2,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    ex_branch_if.slave   bus
);
    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_result;
    logic [4:0]        r_main_rd;
    logic              r_main_wb_en;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_result;
    logic [4:0]        r_skid_rd;
    logic              r_skid_wb_en;
    logic [3:0]        r_kill;
    logic              r_redir_valid;
    logic [ADDR_W-1:0] r_redir_pc;
    logic [CNT_W-1:0]  r_br_cnt;
    logic [CNT_W-1:0]  r_tk_cnt;

    logic              w_accept;
    logic              w_squash;
    logic              w_push;
    logic              w_drain;
    logic              w_is_br;
    logic              w_taken;
    logic              w_wb_en;
    logic [ADDR_W-1:0] w_target;

    assign bus.in_ready = !r_skid_valid && !rst;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_squash     = (r_kill != 4'd0);
    assign w_push       = w_accept && !w_squash;
    assign w_drain      = r_main_valid && bus.out_ready;
    assign w_is_br      = (bus.in_br_type != 2'b00);
    assign w_wb_en      = bus.in_wb_en && !w_is_br;
    assign w_target     = bus.in_pc + (bus.in_imm << 2);

    always_comb begin
        w_taken = 1'b0;
        case (bus.in_br_type)
            2'b01:   w_taken = bus.in_beq;
            2'b10:   w_taken = bus.in_bne;
            2'b11:   w_taken = bus.in_bgt;
            default: w_taken = 1'b0;
        endcase
    end

    // Skid only fills when main is held; it always empties into main first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid  <= 1'b0;
            r_main_result <= '0;
            r_main_rd     <= '0;
            r_main_wb_en  <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_result <= '0;
            r_skid_rd     <= '0;
            r_skid_wb_en  <= 1'b0;
        end else if (w_drain) begin
            if (r_skid_valid) begin
                r_main_result <= r_skid_result;
                r_main_rd     <= r_skid_rd;
                r_main_wb_en  <= r_skid_wb_en;
                r_skid_valid  <= 1'b0;
            end else if (w_push) begin
                r_main_result <= bus.in_result;
                r_main_rd     <= bus.in_rd;
                r_main_wb_en  <= w_wb_en;
            end else begin
                r_main_valid  <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_main_valid) begin
                r_main_valid  <= 1'b1;
                r_main_result <= bus.in_result;
                r_main_rd     <= bus.in_rd;
                r_main_wb_en  <= w_wb_en;
            end else begin
                r_skid_valid  <= 1'b1;
                r_skid_result <= bus.in_result;
                r_skid_rd     <= bus.in_rd;
                r_skid_wb_en  <= w_wb_en;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kill        <= 4'd0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
            r_br_cnt      <= '0;
            r_tk_cnt      <= '0;
        end else begin
            r_redir_valid <= w_push && w_taken;
            if (w_push && w_taken) begin
                r_redir_pc <= w_target;
            end
            if (w_accept) begin
                if (w_squash) begin
                    r_kill <= r_kill - 4'd1;
                end else if (w_taken) begin
                    r_kill <= 4'(KILL_SLOTS);
                end
            end
            if (w_push && w_is_br) begin
                if (r_br_cnt != '1) begin
                    r_br_cnt <= r_br_cnt + CNT_W'(1);
                end
                if (w_taken && (r_tk_cnt != '1)) begin
                    r_tk_cnt <= r_tk_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.out_valid      = r_main_valid;
    assign bus.out_result     = r_main_result;
    assign bus.out_rd         = r_main_rd;
    assign bus.out_wb_en      = r_main_wb_en;
    assign bus.redirect_valid = r_redir_valid;
    assign bus.redirect_pc    = r_redir_pc;
    assign bus.br_count       = r_br_cnt;
    assign bus.taken_count    = r_tk_cnt;
endmodule

// File: tb/tb_ex_branch_stage.sv
// Bench for ex_branch_stage: directed scenarios plus random traffic
// checked against a 2-deep FIFO / kill-window reference model.
module tb_ex_branch_stage;
    localparam int KILL = 2;
    localparam logic [15:0] CMAX = 16'hFFFF;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wb_en;
    } ent_t;

    logic clk;
    logic rst;
    ex_branch_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(16)) bus ();

    ex_branch_stage #(
        .DATA_W(32), .ADDR_W(32), .KILL_SLOTS(KILL), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    ent_t        q[$];
    int          kill;
    logic [15:0] m_br;
    logic [15:0] m_tk;
    logic        m_redir;
    logic [31:0] m_pc;
    logic        last_acc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] res,
                          input logic [1:0] typ, input logic beq,
                          input logic bne, input logic bgt,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [4:0] rd, input logic wb);
        bus.in_valid   = v;
        bus.in_result  = res;
        bus.in_br_type = typ;
        bus.in_beq     = beq;
        bus.in_bne     = bne;
        bus.in_bgt     = bgt;
        bus.in_pc      = pc;
        bus.in_imm     = imm;
        bus.in_rd      = rd;
        bus.in_wb_en   = wb;
    endtask

    task automatic model_clear();
        q.delete();
        kill    = 0;
        m_br    = '0;
        m_tk    = '0;
        m_redir = 1'b0;
    endtask

    // One clock cycle; entered and left at posedge+1.
    task automatic step();
        bit rdy;
        bit acc;
        bit drn;
        bit tk;
        rdy = (q.size() < 2);
        @(negedge clk);
        chk("in_ready", 64'(bus.in_ready), 64'(rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_result", 64'(bus.out_result), 64'(q[0].result));
            chk("out_rd", 64'(bus.out_rd), 64'(q[0].rd));
            chk("out_wb_en", 64'(bus.out_wb_en), 64'(q[0].wb_en));
        end
        acc = bus.in_valid && rdy;
        drn = (q.size() != 0) && bus.out_ready;
        m_redir = 1'b0;
        if (drn) void'(q.pop_front());
        if (acc) begin
            if (kill > 0) begin
                kill--;
            end else begin
                q.push_back('{bus.in_result, bus.in_rd,
                              bus.in_wb_en && (bus.in_br_type == 2'b00)});
                if (bus.in_br_type != 2'b00) begin
                    tk = (bus.in_br_type == 2'b01 && bus.in_beq) ||
                         (bus.in_br_type == 2'b10 && bus.in_bne) ||
                         (bus.in_br_type == 2'b11 && bus.in_bgt);
                    if (m_br != CMAX) m_br++;
                    if (tk) begin
                        if (m_tk != CMAX) m_tk++;
                        m_redir = 1'b1;
                        m_pc    = bus.in_pc + bus.in_imm * 32'd4;
                        kill    = KILL;
                    end
                end
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        chk("redirect_valid", 64'(bus.redirect_valid), 64'(m_redir));
        if (m_redir) chk("redirect_pc", 64'(bus.redirect_pc), 64'(m_pc));
        chk("br_count", 64'(bus.br_count), 64'(m_br));
        chk("taken_count", 64'(bus.taken_count), 64'(m_tk));
    endtask

    // Present the current input until accepted, bounded.
    task automatic push_wait(input string tag);
        int n;
        n = 0;
        step();
        while (!last_acc && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_accept_timeout"}, 64'(last_acc), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_br_count", 64'(bus.br_count), 64'd0);
        chk("rst_taken_count", 64'(bus.taken_count), 64'd0);
        chk("rst_redirect", 64'(bus.redirect_valid), 64'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        last_acc = 1'b0;
        m_pc = '0;
        model_clear();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        set_in(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        #12;
        do_reset();

        // Mid-stream reset with two buffered entries and nonzero stats.
        bus.out_ready = 1'b0;
        set_in(1, 32'hA1, 2'b10, 0, 0, 0, 32'h40, 32'h1, 5'd0, 1);
        push_wait("t1a");
        set_in(1, 32'hA2, 2'b00, 0, 0, 0, 32'h44, 32'h0, 5'd3, 1);
        push_wait("t1b");
        chk("t1_full", 64'(bus.in_ready), 64'd0);
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Back-pressure then release: order preserved.
        bus.out_ready = 1'b0;
        set_in(1, 32'h11, 2'b00, 0, 0, 0, 0, 0, 5'd1, 1);
        push_wait("t2a");
        set_in(1, 32'h22, 2'b00, 0, 0, 0, 0, 0, 5'd2, 1);
        push_wait("t2b");
        chk("t2_held", 64'(bus.out_result), 64'h11);
        chk("t2_in_ready", 64'(bus.in_ready), 64'd0);
        set_in(1, 32'h33, 2'b00, 0, 0, 0, 0, 0, 5'd3, 1);
        for (int i = 0; i < 3; i++) step();
        bus.out_ready = 1'b1;
        push_wait("t2c");
        for (int i = 0; i < 4; i++) step();

        // beq taken, then kill window.
        do_reset();
        set_in(1, 32'hB0, 2'b01, 1, 0, 0, 32'h100, 32'd4, 5'd5, 1);
        push_wait("t3");
        chk("t3_redir", 64'(bus.redirect_valid), 64'd1);
        chk("t3_pc", 64'(bus.redirect_pc), 64'h110);
        chk("t3_br", 64'(bus.br_count), 64'd1);
        chk("t3_tk", 64'(bus.taken_count), 64'd1);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'hC0 + 32'(i), 2'b00, 0, 0, 0, 0, 0, 5'd6, 1);
            push_wait("t3k");
        end
        for (int i = 0; i < 3; i++) step();

        // bne not taken.
        set_in(1, 32'hD0, 2'b10, 0, 0, 1, 32'h200, 32'd8, 5'd7, 1);
        push_wait("t4");
        chk("t4_br", 64'(bus.br_count), 64'd2);
        chk("t4_tk", 64'(bus.taken_count), 64'd1);
        step();

        // Target wrap and negative offset.
        set_in(1, 32'hE0, 2'b11, 0, 0, 1, 32'hFFFF_FFFC, 32'd1, 5'd8, 0);
        push_wait("t5a");
        chk("t5a_pc", 64'(bus.redirect_pc), 64'h0);
        for (int i = 0; i < KILL; i++) begin
            set_in(1, 32'hE1, 2'b00, 0, 0, 0, 0, 0, 5'd9, 1);
            push_wait("t5k");
        end
        set_in(1, 32'hE2, 2'b01, 1, 0, 0, 32'h10, 32'hFFFF_FFFC, 5'd9, 1);
        push_wait("t5b");
        chk("t5b_pc", 64'(bus.redirect_pc), 64'h0);

        // Taken bgt inside the kill window is discarded.
        set_in(1, 32'hF0, 2'b11, 0, 0, 1, 32'h300, 32'd2, 5'd10, 1);
        push_wait("t6");
        chk("t6_no_redir", 64'(bus.redirect_valid), 64'd0);
        for (int i = 0; i < 4; i++) step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom, $urandom, 5'($urandom), 1'($urandom));
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Saturation of br_count.
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            set_in(1, 32'(i), 2'b10, 0, 0, 0, 0, 0, 5'd1, 1);
            step();
        end
        chk("sat_pre", 64'(bus.br_count), 64'hFFFF);
        set_in(1, 32'h5A, 2'b10, 0, 0, 0, 0, 0, 5'd1, 1);
        step();
        chk("sat_post", 64'(bus.br_count), 64'hFFFF);
        chk("sat_tk", 64'(bus.taken_count), 64'd0);
        bus.in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
